// File: rtl/lpc_sniffer_pkg.sv
// Shared types and helpers for the LPC sniffer capture path.
// Holds the frame-drain state encoding, ASCII constants and nibble-to-hex conversion.
package lpc_sniffer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        BANG,
        NIB,
        NL,
        ACK
    } drain_state_t;

    localparam logic [7:0] ASCII_BANG = 8'h21;
    localparam logic [7:0] ASCII_NL   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        logic [7:0] w_n;
        w_n = {4'h0, n};
        if (n < 4'd10) begin
            return ASCII_0 + w_n;
        end
        return ASCII_A + (w_n - 8'd10);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// RST_VAL sets the value the output holds while reset is asserted.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/lpc_frame_drain.sv
// Drains captured frames from the ring buffer and prints each as an ASCII hex line.
// A '!' prefix marks that the buffer overflowed since the previous line.
module lpc_frame_drain
    import lpc_sniffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HOLDOFF    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty,
    input  logic                  overflow,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  read_done,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int NIBS  = DATA_WIDTH / 4;
    localparam int CNT_W = $clog2(NIBS + 1);
    localparam int HO_W  = $clog2(HOLDOFF + 1);

    drain_state_t          r_state;
    drain_state_t          w_next;
    logic                  w_empty_s;
    logic                  w_ovf_s;
    logic                  r_ovf_pending;
    logic [HO_W-1:0]       r_holdoff;
    logic [CNT_W-1:0]      r_nib_cnt;
    logic [DATA_WIDTH-1:0] r_shift;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_empty (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (empty),
        .o_q     (w_empty_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_ovf (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (overflow),
        .o_q     (w_ovf_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are pure functions of state, so a stalled byte cannot change under tx_ready=0.
    always_comb begin
        w_next    = r_state;
        ram_re    = 1'b0;
        read_done = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (r_state)
            IDLE: begin
                if (!w_empty_s && (r_holdoff == '0)) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                ram_re = 1'b1;
                w_next = LATCH;
            end
            LATCH: begin
                w_next = r_ovf_pending ? BANG : NIB;
            end
            BANG: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_BANG;
                if (tx_ready) begin
                    w_next = NIB;
                end
            end
            NIB: begin
                tx_valid = 1'b1;
                tx_data  = nib2ascii(r_shift[DATA_WIDTH-1 -: 4]);
                if (tx_ready && (r_nib_cnt == CNT_W'(1))) begin
                    w_next = NL;
                end
            end
            NL: begin
                tx_valid = 1'b1;
                tx_data  = ASCII_NL;
                if (tx_ready) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                read_done = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Overflow seen in the same cycle as the '!' is accepted must not be lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_pending <= 1'b0;
            r_holdoff     <= '0;
            r_nib_cnt     <= '0;
        end else begin
            if (w_ovf_s) begin
                r_ovf_pending <= 1'b1;
            end else if ((r_state == BANG) && tx_ready) begin
                r_ovf_pending <= 1'b0;
            end

            if (r_state == ACK) begin
                r_holdoff <= HO_W'(HOLDOFF);
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end

            if (r_state == LATCH) begin
                r_nib_cnt <= CNT_W'(NIBS);
            end else if ((r_state == NIB) && tx_ready) begin
                r_nib_cnt <= r_nib_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == LATCH) begin
            r_shift <= ram_rdata;
        end else if ((r_state == NIB) && tx_ready) begin
            r_shift <= {r_shift[DATA_WIDTH-5:0], 4'h0};
        end
    end

endmodule

// File: tb/tb_lpc_frame_drain.sv
// Bench for lpc_frame_drain: ring-buffer/RAM model plus a byte scoreboard.
module tb_lpc_frame_drain;

    localparam int DW = 32;
    localparam int HO = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          empty;
    logic          overflow = 1'b0;
    logic          ram_re;
    logic [DW-1:0] ram_rdata = '0;
    logic          read_done;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;

    logic [DW-1:0] mem [16];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic [7:0]    exp_q [$];
    int            total = 0;
    int            bad = 0;

    lpc_frame_drain #(.DATA_WIDTH(DW), .HOLDOFF(HO)) dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .overflow  (overflow),
        .ram_re    (ram_re),
        .ram_rdata (ram_rdata),
        .read_done (read_done),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // Ring buffer: empty while pointers match; read_done advances the read pointer.
    assign empty = (rd_ptr == wr_ptr);

    always @(negedge clk) begin
        if (ram_re) ram_rdata <= mem[rd_ptr % 16];
        if (read_done) rd_ptr <= rd_ptr + 1;
    end

    task automatic push_expect(input logic [DW-1:0] f, input bit bang);
        logic [3:0] n;
        if (bang) exp_q.push_back(8'h21);
        for (int i = DW/4 - 1; i >= 0; i--) begin
            n = f[i*4 +: 4];
            exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
        end
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_frame(input logic [DW-1:0] f, input bit bang);
        push_expect(f, bang);
        mem[wr_ptr % 16] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        total++; if (ram_re !== 1'b0) begin bad++; $display("FAIL reset_ram_re got=%b want=0", ram_re); end
        total++; if (read_done !== 1'b0) begin bad++; $display("FAIL reset_read_done got=%b want=0", read_done); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        int re_cnt = 0;
        int rd_cnt = 0;
        int first = -1;
        int last = -1;
        int re_at = -1;
        logic [7:0] e;
        tx_ready = 1'b1;
        @(negedge clk);
        push_frame(32'hDEADBEEF, 1'b0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ram_re) begin re_cnt++; re_at = c; end
            if (read_done) rd_cnt++;
            if (tx_valid && tx_ready) begin
                if (first < 0) first = c;
                last = c;
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL single_extra_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin bad++; $display("FAIL single_byte got=%h want=%h", tx_data, e); end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing left=%0d want=0", exp_q.size()); end
        total++; if (rd_cnt != 1) begin bad++; $display("FAIL single_read_done got=%0d want=1", rd_cnt); end
        total++; if (re_cnt != 1) begin bad++; $display("FAIL single_ram_re got=%0d want=1", re_cnt); end
        total++; if (last - first != 8) begin bad++; $display("FAIL single_consecutive span=%0d want=8", last - first); end
        total++; if (first - re_at != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", first - re_at); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        bit prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic [7:0] e;
        @(negedge clk);
        push_frame(32'hDEADBEEF, 1'b0);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            tx_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (read_done) rd_cnt++;
            if (prev_stall) begin
                total++;
                if (!tx_valid || tx_data !== prev_data) begin
                    bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL bp_extra_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin bad++; $display("FAIL bp_byte got=%h want=%h", tx_data, e); end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_missing left=%0d want=0", exp_q.size()); end
        total++; if (rd_cnt != 1) begin bad++; $display("FAIL bp_read_done got=%0d want=1", rd_cnt); end
        exp_q.delete();
        tx_ready = 1'b1;
    endtask

    task automatic test_overflow();
        int rd_cnt = 0;
        logic [7:0] e;
        tx_ready = 1'b1;
        @(negedge clk);
        overflow = 1'b1;
        repeat (5) @(negedge clk);
        overflow = 1'b0;
        repeat (5) @(negedge clk);
        push_frame(32'h0000000A, 1'b1);
        push_frame(32'h00C0FFEE, 1'b0);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (read_done) rd_cnt++;
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL ovf_extra_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin bad++; $display("FAIL ovf_byte got=%h want=%h", tx_data, e); end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_missing left=%0d want=0", exp_q.size()); end
        total++; if (rd_cnt != 2) begin bad++; $display("FAIL ovf_read_done got=%0d want=2", rd_cnt); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int rd_cnt = 0;
        int rd_at0 = -1;
        int rd_at1 = -1;
        logic [7:0] e;
        tx_ready = 1'b1;
        @(negedge clk);
        push_frame(32'h12345678, 1'b0);
        push_frame(32'h9ABCDEF0, 1'b0);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (read_done) begin
                if (rd_cnt == 0) rd_at0 = c; else rd_at1 = c;
                rd_cnt++;
            end
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin bad++; $display("FAIL b2b_byte got=%h want=%h", tx_data, e); end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing left=%0d want=0", exp_q.size()); end
        total++; if (rd_cnt != 2) begin bad++; $display("FAIL b2b_read_done got=%0d want=2", rd_cnt); end
        total++;
        if (rd_at1 - rd_at0 < HO + 1) begin
            bad++; $display("FAIL b2b_gap got=%0d want>=%0d", rd_at1 - rd_at0, HO + 1);
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        int rd_cnt = 0;
        int xfers = 0;
        logic [7:0] e;
        tx_ready = 1'b1;
        @(negedge clk);
        push_frame(32'hCAFEF00D, 1'b0);
        for (int c = 0; c < 60 && xfers < 3; c++) begin
            @(negedge clk);
            if (read_done) rd_cnt++;
            if (tx_valid && tx_ready) begin
                xfers++;
                total++;
                e = exp_q.pop_front();
                if (tx_data !== e) begin bad++; $display("FAIL rst_pre_byte got=%h want=%h", tx_data, e); end
            end
        end
        total++;
        if (xfers != 3) begin
            bad++; $display("FAIL rst_pre_timeout got=%0d want=3", xfers);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_tx_valid got=%b want=0", tx_valid); end
        total++; if (read_done !== 1'b0) begin bad++; $display("FAIL rst_mid_read_done got=%b want=0", read_done); end
        exp_q.delete();
        push_expect(32'hCAFEF00D, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (read_done) rd_cnt++;
        end
        reset = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (read_done) rd_cnt++;
            if (tx_valid && tx_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rst_extra_byte got=%h want=none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin bad++; $display("FAIL rst_post_byte got=%h want=%h", tx_data, e); end
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_missing left=%0d want=0", exp_q.size()); end
        total++; if (rd_cnt != 1) begin bad++; $display("FAIL rst_read_done got=%0d want=1", rd_cnt); end
        exp_q.delete();
    endtask

    task automatic test_idle();
        int activity = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (ram_re || tx_valid || read_done) activity++;
        end
        total++; if (activity != 0) begin bad++; $display("FAIL idle_activity got=%0d want=0", activity); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
